resp_signature_capture: RTL and testbench

Response-side companion to the randomized stimulus driver used in fuzz cycles. It samples the DUT's flat output bus once per clock for a programmed number of cycles and compacts it into a 32-bit MISR signature. The signature is presented on a valid/ready port, so two simulators, or silicon and a model, can be compared with one word instead of a full per-cycle trace. It sits beside the DUT and taps `out_flat` directly.

---
 rtl/resp_signature_capture_if.sv | 32 +++
 rtl/resp_signature_capture.sv | 134 +++++++++++++
 tb/tb_resp_signature_capture.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/resp_signature_capture_if.sv
// -----------------------------------------------------------------------------
// resp_signature_capture_if
//   Groups the control, observed-bus and signature-handshake signals of
//   resp_signature_capture.
//   master : test controller side (drives start/abort/cycles/out_flat/sig_ready)
//   slave  : capture block side (drives busy/sig_valid/sig_data/sig_count)
// -----------------------------------------------------------------------------
interface resp_signature_capture_if #(
  parameter int OUT_W = 159,
  parameter int SIG_W = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cycles;
  logic [OUT_W-1:0] out_flat;
  logic             busy;
  logic             sig_valid;
  logic             sig_ready;
  logic [SIG_W-1:0] sig_data;
  logic [CNT_W-1:0] sig_count;

  modport master (
    output start, abort, cycles, out_flat, sig_ready,
    input  busy, sig_valid, sig_data, sig_count
  );

  modport slave (
    input  start, abort, cycles, out_flat, sig_ready,
    output busy, sig_valid, sig_data, sig_count
  );
endinterface

// File: rtl/resp_signature_capture.sv
// -----------------------------------------------------------------------------
// resp_signature_capture
//   Samples a DUT output bus once per clock for a programmed number of cycles,
//   compacts each sample with an XOR fold and a 32-bit MISR, then offers the
//   signature on a valid/ready port.
// Ports:
//   clk   : sole clock, posedge
//   rst_n : asynchronous active-low reset
//   bus   : resp_signature_capture_if.slave
//           start/abort/cycles  run control (start honoured only in IDLE)
//           out_flat            observed DUT bus
//           busy                high in CAPTURE and REPORT
//           sig_valid/sig_ready signature handshake
//           sig_data/sig_count  signature and number of folded samples
// -----------------------------------------------------------------------------
module resp_signature_capture #(
  parameter int                   OUT_W = 159,
  parameter int                   SIG_W = 32,
  parameter int                   CNT_W = 16,
  parameter logic [SIG_W-1:0]     POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]     SEED  = 32'hFFFFFFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  resp_signature_capture_if.slave  bus
);

  localparam int NCHUNK = (OUT_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W  = NCHUNK * SIG_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SIG_W-1:0] sig_q, sig_d;

  // ---------------------------------------------------------------------------
  // Fold: zero-extend the bus to a whole number of chunks, XOR them together.
  // ---------------------------------------------------------------------------
  logic [PAD_W-1:0] padded;
  logic [SIG_W-1:0] chunk [NCHUNK];
  logic [SIG_W-1:0] fold;
  logic [SIG_W-1:0] misr_next;

  assign padded = PAD_W'(bus.out_flat);

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign chunk[gi] = padded[gi*SIG_W +: SIG_W];
    end
  endgenerate

  always_comb begin
    fold = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      fold = fold ^ chunk[i];
    end
  end

  assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                   ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ fold;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    sig_d       = sig_q;

    if (bus.abort) begin
      // Abort wins over start and handshake; signature/count keep last values.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            remaining_d = bus.cycles;
            count_d     = '0;
            sig_d       = SEED;
            state_d     = (bus.cycles == '0) ? ST_REPORT : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          sig_d       = misr_next;
          remaining_d = remaining_q - 1'b1;
          if (count_q != '1) begin
            count_d = count_q + 1'b1;
          end
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (bus.sig_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      count_q     <= '0;
      sig_q       <= SEED;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      sig_q       <= sig_d;
    end
  end

  // Outputs decode registers only; no input reaches an output combinationally.
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sig_valid = (state_q == ST_REPORT);
  assign bus.sig_data  = sig_q;
  assign bus.sig_count = count_q;

endmodule

// File: tb/tb_resp_signature_capture.sv
module tb_resp_signature_capture;

  localparam int          OUT_W = 159;
  localparam int          SIG_W = 32;
  localparam int          CNT_W = 16;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'hFFFFFFFF;

  logic clk;
  logic rst_n;

  resp_signature_capture_if #(.OUT_W(OUT_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) bus ();

  resp_signature_capture #(
    .OUT_W(OUT_W), .SIG_W(SIG_W), .CNT_W(CNT_W), .POLY(POLY), .SEED(SEED)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] lcg = 32'h1234_5678;
  logic [47:0] sb_q[$];   // {sig, count}
  logic [31:0] m_sig;     // bench model signature of the run in progress

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fold by bit position modulo the signature width.
  function automatic logic [31:0] model_fold(input logic [OUT_W-1:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < OUT_W; i++) f[i % 32] = f[i % 32] ^ v[i];
    return f;
  endfunction

  function automatic logic [31:0] model_misr(input logic [31:0] s, input logic [OUT_W-1:0] v);
    logic [31:0] n;
    n = {s[30:0], 1'b0};
    if (s[31]) n = n ^ POLY;
    return n ^ model_fold(v);
  endfunction

  task automatic gen_flat(input int mode, output logic [OUT_W-1:0] v);
    logic [159:0] t;
    t = '0;
    case (mode)
      1: t[0] = 1'b1;
      2: t[128] = 1'b1;
      3: for (int w = 0; w < 5; w++) begin
           lcg = lcg * 32'd1664525 + 32'd1013904223;
           t[w*32 +: 32] = lcg;
         end
      default: t = '0;
    endcase
    v = t[OUT_W-1:0];
  endtask

  // Start a run of c samples and leave the DUT in REPORT; expectation pushed.
  task automatic run(input string tag, input int c, input int mode);
    logic [OUT_W-1:0] v;
    m_sig = SEED;
    bus.start  = 1'b1;
    bus.cycles = CNT_W'(c);
    tick();
    bus.start  = 1'b0;
    bus.cycles = CNT_W'($urandom);   // changes after acceptance must not matter
    chk({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
    for (int k = 0; k < c; k++) begin
      gen_flat(mode, v);
      bus.out_flat = v;
      m_sig = model_misr(m_sig, v);
      tick();
      chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      chk({tag, "_valid_step"}, 64'(bus.sig_valid), 64'(k == c - 1));
    end
    sb_q.push_back({m_sig, 16'(c)});
    chk({tag, "_valid"}, 64'(bus.sig_valid), 64'd1);
  endtask

  // Compare the presented signature against the oldest expectation and let
  // the next edge complete the transfer.
  task automatic consume(input string tag);
    logic [47:0] e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s_sb_empty observed=0 expected=1 entries", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_sig"}, 64'(bus.sig_data), 64'(e[47:16]));
      chk({tag, "_cnt"}, 64'(bus.sig_count), 64'(e[15:0]));
      $display("xfer %s sig=%08h count=%0d", tag, bus.sig_data, bus.sig_count);
    end
    bus.sig_ready = 1'b1;
    tick();
    chk({tag, "_valid_drop"}, 64'(bus.sig_valid), 64'd0);
    chk({tag, "_busy_drop"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [OUT_W-1:0] v;
    logic [31:0] snap;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cycles = '0;
    bus.out_flat = '0; bus.sig_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.sig_valid), 64'd0);
    chk("rst_sig",   64'(bus.sig_data), 64'(SEED));
    chk("rst_cnt",   64'(bus.sig_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Zero-cycle run goes straight to REPORT.
    bus.sig_ready = 1'b1;
    run("c0", 0, 0);
    consume("c0");

    // Single sample of zeros with ready held high: busy for exactly 2 cycles.
    run("c1_zero", 1, 0);
    chk("c1_zero_const", 64'(bus.sig_data), 64'h0FB3EE249);
    consume("c1_zero");

    run("c1_bit0", 1, 1);
    chk("c1_bit0_const", 64'(bus.sig_data), 64'h0FB3EE248);
    consume("c1_bit0");

    run("c1_bit128", 1, 2);
    chk("c1_bit128_const", 64'(bus.sig_data), 64'h0FB3EE248);
    consume("c1_bit128");

    // Long LCG run with backpressure.
    bus.sig_ready = 1'b0;
    run("c200", 200, 3);
    snap = bus.sig_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("c200_hold_valid", 64'(bus.sig_valid), 64'd1);
      chk("c200_hold_sig", 64'(bus.sig_data), 64'(snap));
    end
    consume("c200");
    bus.sig_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("c200_one_xfer", 64'(bus.sig_valid), 64'd0);
    end

    // Abort at sample 5 of 20 together with start.
    m_sig = SEED;
    bus.start = 1'b1; bus.cycles = 16'd20;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gen_flat(3, v);
      bus.out_flat = v;
      m_sig = model_misr(m_sig, v);
      tick();
    end
    gen_flat(3, v);
    bus.out_flat = v;
    bus.abort = 1'b1; bus.start = 1'b1;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("abort_valid", 64'(bus.sig_valid), 64'd0);
    chk("abort_busy",  64'(bus.busy), 64'd0);
    chk("abort_cnt",   64'(bus.sig_count), 64'd4);
    chk("abort_sig",   64'(bus.sig_data), 64'(m_sig));
    tick();
    chk("abort_idle_valid", 64'(bus.sig_valid), 64'd0);
    chk("abort_idle_busy",  64'(bus.busy), 64'd0);
    bus.sig_ready = 1'b1;
    run("after_abort", 20, 3);
    consume("after_abort");

    // Asynchronous reset while in REPORT.
    bus.sig_ready = 1'b0;
    run("rst_mid", 3, 3);
    tick();
    chk("rst_mid_pre_valid", 64'(bus.sig_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.sig_valid), 64'd0);
    chk("rst_mid_busy",  64'(bus.busy), 64'd0);
    chk("rst_mid_cnt",   64'(bus.sig_count), 64'd0);
    chk("rst_mid_sig",   64'(bus.sig_data), 64'(SEED));
    void'(sb_q.pop_front());
    tick();
    rst_n = 1'b1;
    tick();
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
